// File: rtl/fetch_instr_queue.sv
// Dual-issue Fetch->Decode instruction queue; optional same-cycle bypass via IBUF_BYPASS_EN.
// Latency: 1 cycle from push to output (0 cycles when IBUF_BYPASS_EN and the queue is nearly empty).
// Backpressure: in_ready drops when fewer than 2 slots are free; pushes while !in_ready are dropped.
module fetch_instr_queue #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid_a,
    input  logic [DW-1:0]            in_pc_a,
    input  logic [DW-1:0]            in_instr_a,
    input  logic                     in_valid_b,
    input  logic [DW-1:0]            in_pc_b,
    input  logic [DW-1:0]            in_instr_b,
    output logic                     in_ready,
    output logic                     out_valid_a,
    output logic [DW-1:0]            out_pc_a,
    output logic [DW-1:0]            out_instr_a,
    output logic                     out_valid_b,
    output logic [DW-1:0]            out_pc_b,
    output logic [DW-1:0]            out_instr_b,
    input  logic [1:0]               out_take,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW-1:0] head_p1, tail_p1;

    entry_t     ent_a, ent_b, sel_a, sel_b, wr_0;
    logic [1:0] take, n_in, n_out, st_vis, avail, pop_st, n_byp, n_wr;
    logic [2:0] vis_sum;

    assign ent_a   = '{pc: in_pc_a, instr: in_instr_a};
    assign ent_b   = '{pc: in_pc_b, instr: in_instr_b};
    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);

    // Credit comes only from registered occupancy, never from a same-cycle pop.
    assign in_ready = (count <= CW'(DEPTH - 2));

    always_comb begin
        take = (out_take == 2'd3) ? 2'd2 : out_take;
        n_in = 2'd0;
        if (in_ready && in_valid_a) begin
            n_in = in_valid_b ? 2'd2 : 2'd1;
        end
        st_vis  = (count >= CW'(2)) ? 2'd2 : count[1:0];
        vis_sum = {1'b0, st_vis} + {1'b0, n_in};
`ifdef IBUF_BYPASS_EN
        avail = flush ? st_vis : ((vis_sum >= 3'd2) ? 2'd2 : vis_sum[1:0]);
`else
        avail = st_vis;
`endif
        n_out  = (take < avail) ? take : avail;
        // Stored entries are older than incoming ones, so pops drain storage first.
        pop_st = (n_out < st_vis) ? n_out : st_vis;
        n_byp  = n_out - pop_st;
        n_wr   = n_in - n_byp;
        wr_0   = (n_byp == 2'd0) ? ent_a : ent_b;
    end

    always_comb begin
        sel_a = mem[head];
        sel_b = mem[head_p1];
`ifdef IBUF_BYPASS_EN
        if (st_vis == 2'd0) begin
            sel_a = ent_a;
            sel_b = ent_b;
        end else if (st_vis == 2'd1) begin
            sel_b = ent_a;
        end
`endif
        out_valid_a = !reset && (avail >= 2'd1);
        out_valid_b = !reset && (avail == 2'd2);
        out_pc_a    = out_valid_a ? sel_a.pc    : '0;
        out_instr_a = out_valid_a ? sel_a.instr : '0;
        out_pc_b    = out_valid_b ? sel_b.pc    : '0;
        out_instr_b = out_valid_b ? sel_b.instr : '0;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_st);
            tail  <= tail + PW'(n_wr);
            count <= count + CW'(n_in) - CW'(n_out);
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (n_wr != 2'd0) begin
                mem[tail] <= wr_0;
            end
            if (n_wr == 2'd2) begin
                mem[tail_p1] <= ent_b;
            end
        end
    end

    a_count_max: assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
    a_b_needs_a: assert property (@(posedge clk) disable iff (reset)
                                  (in_valid_b && !in_valid_a) |-> (n_in == 2'd0));
    a_byp_le_in: assert property (@(posedge clk) disable iff (reset) n_byp <= n_in);

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Scoreboard bench for fetch_instr_queue; the model follows IBUF_BYPASS_EN when it is defined.
module tb_fetch_instr_queue;
    localparam int DEPTH = 8;
    localparam int DW    = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid_a = 1'b0;
    logic [DW-1:0] in_pc_a = '0;
    logic [DW-1:0] in_instr_a = '0;
    logic          in_valid_b = 1'b0;
    logic [DW-1:0] in_pc_b = '0;
    logic [DW-1:0] in_instr_b = '0;
    logic          in_ready;
    logic          out_valid_a;
    logic [DW-1:0] out_pc_a;
    logic [DW-1:0] out_instr_a;
    logic          out_valid_b;
    logic [DW-1:0] out_pc_b;
    logic [DW-1:0] out_instr_b;
    logic [1:0]    out_take = 2'd0;
    logic [3:0]    count;

    ent_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] pc_ctr = 32'h1000;

    fetch_instr_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid_a(in_valid_a), .in_pc_a(in_pc_a), .in_instr_a(in_instr_a),
        .in_valid_b(in_valid_b), .in_pc_b(in_pc_b), .in_instr_b(in_instr_b),
        .in_ready(in_ready),
        .out_valid_a(out_valid_a), .out_pc_a(out_pc_a), .out_instr_a(out_instr_a),
        .out_valid_b(out_valid_b), .out_pc_b(out_pc_b), .out_instr_b(out_instr_b),
        .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0; out_take = 2'd0;
    endtask

    // One cycle of stimulus: outputs are checked against the model, then the model advances.
    task automatic step(input logic va, input logic [31:0] pca, input logic [31:0] ia,
                        input logic vb, input logic [31:0] pcb, input logic [31:0] ib,
                        input logic [1:0] take, input logic fl);
        ent_t vis[$];
        ent_t ea, eb;
        logic acc;
        int   nv, nt;
        @(negedge clk);
        in_valid_a = va; in_pc_a = pca; in_instr_a = ia;
        in_valid_b = vb; in_pc_b = pcb; in_instr_b = ib;
        out_take = take; flush = fl;
        #1;
        acc = va && (q.size() <= DEPTH - 2);
        check("in_ready", 64'(in_ready), 64'(q.size() <= DEPTH - 2));
        check("count", 64'(count), 64'(q.size()));
        for (int i = 0; i < q.size() && i < 2; i++) vis.push_back(q[i]);
`ifdef IBUF_BYPASS_EN
        if (!fl && acc) begin
            if (vis.size() < 2) vis.push_back({pca, ia});
            if (vb && vis.size() < 2) vis.push_back({pcb, ib});
        end
`endif
        nv = vis.size();
        ea = (nv >= 1) ? vis[0] : '0;
        eb = (nv >= 2) ? vis[1] : '0;
        check("out_valid_a", 64'(out_valid_a), 64'(nv >= 1));
        check("out_valid_b", 64'(out_valid_b), 64'(nv >= 2));
        check("out_pc_a", 64'(out_pc_a), 64'(ea.pc));
        check("out_instr_a", 64'(out_instr_a), 64'(ea.instr));
        check("out_pc_b", 64'(out_pc_b), 64'(eb.pc));
        check("out_instr_b", 64'(out_instr_b), 64'(eb.instr));
        if (fl) begin
            q.delete();
        end else begin
            if (acc) begin
                q.push_back({pca, ia});
                if (vb) q.push_back({pcb, ib});
            end
            nt = (take == 2'd3) ? 2 : int'(take);
            if (nt > nv) nt = nv;
            repeat (nt) void'(q.pop_front());
        end
    endtask

    task automatic push2(input logic [1:0] take);
        step(1'b1, pc_ctr, $urandom, 1'b1, pc_ctr + 32'd4, $urandom, take, 1'b0);
        pc_ctr += 32'd8;
    endtask

    task automatic settle();
        @(negedge clk);
        idle_inputs();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("rst_valid_a", 64'(out_valid_a), 64'(0));
        check("rst_valid_b", 64'(out_valid_b), 64'(0));
        check("rst_pc_a", 64'(out_pc_a), 64'(0));
        check("rst_instr_b", 64'(out_instr_b), 64'(0));
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Two-wide push, nothing taken.
        step(1'b1, 32'h0, 32'h11, 1'b1, 32'h4, 32'h22, 2'd0, 1'b0);
        settle();
        check("t1_count", 64'(count), 64'(2));
        check("t1_pc_a", 64'(out_pc_a), 64'(32'h0));
        check("t1_instr_b", 64'(out_instr_b), 64'(32'h22));
        check("t1_valid_b", 64'(out_valid_b), 64'(1));

        // Fill to DEPTH, then a dropped push.
        repeat (3) push2(2'd0);
        settle();
        check("t2_count_full", 64'(count), 64'(8));
        check("t2_ready_full", 64'(in_ready), 64'(0));
        push2(2'd0);
        settle();
        check("t2_count_drop", 64'(count), 64'(8));

        // Pop to 7, then pop+push at 7: the push is refused.
        step(1'b0, 0, 0, 1'b0, 0, 0, 2'd1, 1'b0);
        settle();
        check("t3_ready_7", 64'(in_ready), 64'(0));
        push2(2'd1);
        settle();
        check("t3_count_6", 64'(count), 64'(6));
        for (int i = 0; i < 8; i++) push2(2'd2);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 1'b0, 0, 0, 2'd3, 1'b0);

        // Reach 5, then flush with a simultaneous push and pop.
        for (int i = 0; i < 12 && q.size() != 5; i++) begin
            if (q.size() < 5) begin
                step(1'b1, pc_ctr, $urandom, 1'b0, 0, 0, 2'd0, 1'b0);
                pc_ctr += 32'd4;
            end else begin
                step(1'b0, 0, 0, 1'b0, 0, 0, 2'd1, 1'b0);
            end
        end
        settle();
        check("t4_count_5", 64'(count), 64'(5));
        step(1'b1, 32'hdead0, 32'h1, 1'b1, 32'hdead4, 32'h2, 2'd2, 1'b1);
        settle();
        check("t4_count", 64'(count), 64'(0));
        check("t4_valid_a", 64'(out_valid_a), 64'(0));
        check("t4_ready", 64'(in_ready), 64'(1));

        // Over-take at count 1, then a lone slot-B push.
        step(1'b1, 32'h200, 32'h33, 1'b0, 0, 0, 2'd0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 0, 0, 2'd2, 1'b0);
        settle();
        check("t5_count", 64'(count), 64'(0));
        step(1'b0, 0, 0, 1'b1, 32'h300, 32'h44, 2'd0, 1'b0);
        settle();
        check("t5_b_only", 64'(count), 64'(0));
        check("t5_b_only_va", 64'(out_valid_a), 64'(0));

        // Empty-queue push with one taken in the same cycle.
        step(1'b1, 32'h100, 32'h55, 1'b1, 32'h104, 32'h66, 2'd1, 1'b0);
        settle();
`ifdef IBUF_BYPASS_EN
        check("t6_count", 64'(count), 64'(1));
        check("t6_pc_a", 64'(out_pc_a), 64'(32'h104));
`else
        check("t6_count", 64'(count), 64'(2));
        check("t6_pc_a", 64'(out_pc_a), 64'(32'h100));
`endif

        // Reset while occupied.
        push2(2'd0);
        do_reset();

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, pc_ctr, $urandom, $urandom_range(0, 1) == 1,
                 pc_ctr + 32'd4, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 40) == 0);
            pc_ctr += 32'd8;
        end
        settle();
        check("final_count", 64'(count), 64'(q.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
